// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU, DMA and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_w;
    logic              mem_r;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_adr, mem_din, mem_w, mem_r,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_adr, mem_din, mem_w, mem_r,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, DMA is guaranteed a slot after
// STARVE_MAX consecutive denied cycles. Reads return registered data one cycle later.
module dmem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_arbiter_if.slave bus,
    output logic [1:0] owner
);
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } ownerT;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starveCnt;
    logic       forceDma;
    logic       cpuGnt;
    logic       dmaGnt;
    ownerT      state;
    ownerT      stateNext;

    // Grants are purely combinational so the stall reaches the pipeline in the same cycle.
    assign forceDma = (starveCnt == STARVE_LIM);
    assign dmaGnt   = rst_n & bus.dma_req & (~bus.cpu_req | forceDma);
    assign cpuGnt   = rst_n & bus.cpu_req & ~dmaGnt;

    assign bus.cpu_stall = bus.cpu_req & ~cpuGnt;
    assign bus.dma_gnt   = dmaGnt;

    assign bus.mem_adr = dmaGnt ? bus.dma_addr  : bus.cpu_addr;
    assign bus.mem_din = dmaGnt ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.mem_w   = (cpuGnt & bus.cpu_we) | (dmaGnt & bus.dma_we);
    assign bus.mem_r   = (cpuGnt & ~bus.cpu_we) | (dmaGnt & ~bus.dma_we);

    // Counts consecutive cycles the DMA asked and was refused; saturates at the forcing level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starveCnt <= 4'd0;
        end else if (dmaGnt) begin
            starveCnt <= 4'd0;
        end else if (bus.dma_req && (starveCnt != STARVE_LIM)) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end

    // Each port captures memory data only for its own granted read; the other port holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.cpu_rdata  <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.dma_rdata  <= '0;
            bus.dma_rvalid <= 1'b0;
        end else begin
            bus.cpu_rvalid <= cpuGnt & ~bus.cpu_we;
            bus.dma_rvalid <= dmaGnt & ~bus.dma_we;
            if (cpuGnt && !bus.cpu_we) begin
                bus.cpu_rdata <= bus.mem_dout;
            end
            if (dmaGnt && !bus.dma_we) begin
                bus.dma_rdata <= bus.mem_dout;
            end
        end
    end

    // Last-owner record, kept only for debug visibility.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OWN_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = OWN_IDLE;
        if (dmaGnt) begin
            stateNext = OWN_DMA;
        end else if (cpuGnt) begin
            stateNext = OWN_CPU;
        end
    end

    assign owner = state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter, compared cycle by cycle against a
// behavioural model that tracks DMA wait count, a reference memory and expected read data.
module tb_dmem_arbiter;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] owner;
    logic       clearMem;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: asynchronous read, write on the rising edge.
    logic [31:0] memArray [32];
    assign bus.mem_dout = memArray[bus.mem_adr];
    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < 32; i++) memArray[i] <= 32'd0;
        end else if (bus.mem_w) begin
            memArray[bus.mem_adr] <= bus.mem_din;
        end
    end

    // Reference model state
    logic [31:0] refMem [32];
    int          dmaWaits;
    logic [31:0] expCpuRdata;
    logic [31:0] expDmaRdata;
    logic        expCpuRvalid;
    logic        expDmaRvalid;
    logic        lastCpuGnt;
    logic        lastDmaGnt;

    int checkCount;
    int passCount;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, check the combinational decision, clock, check registered results.
    task automatic applyStimulus(
        input logic        rstN,
        input logic        cReq, input logic cWe, input logic [4:0] cAddr, input logic [31:0] cData,
        input logic        dReq, input logic dWe, input logic [4:0] dAddr, input logic [31:0] dData,
        input logic        dropRst
    );
        logic mCpu;
        logic mDma;
        logic edgeRst;
        @(negedge clk);
        rst_n         = rstN;
        bus.cpu_req   = cReq;
        bus.cpu_we    = cWe;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = cData;
        bus.dma_req   = dReq;
        bus.dma_we    = dWe;
        bus.dma_addr  = dAddr;
        bus.dma_wdata = dData;
        #1;
        mDma = rstN && dReq && (!cReq || (dmaWaits >= STARVE_MAX));
        mCpu = rstN && cReq && !mDma;
        checkOutput("cpu_stall", 32'(bus.cpu_stall), 32'(cReq && !mCpu));
        checkOutput("dma_gnt",   32'(bus.dma_gnt),   32'(mDma));
        checkOutput("mem_w",     32'(bus.mem_w),     32'((mCpu && cWe) || (mDma && dWe)));
        checkOutput("mem_r",     32'(bus.mem_r),     32'((mCpu && !cWe) || (mDma && !dWe)));
        checkOutput("mem_adr",   32'(bus.mem_adr),   32'(mDma ? dAddr : cAddr));
        checkOutput("mem_din",   bus.mem_din,        mDma ? dData : cData);
        edgeRst = !rstN;
        if (dropRst) begin
            rst_n   = 1'b0;
            edgeRst = 1'b1;
            mCpu    = 1'b0;
            mDma    = 1'b0;
            #1;
        end
        lastCpuGnt = mCpu;
        lastDmaGnt = mDma;
        @(posedge clk);
        #1;
        if (edgeRst) begin
            dmaWaits     = 0;
            expCpuRdata  = 32'd0;
            expDmaRdata  = 32'd0;
            expCpuRvalid = 1'b0;
            expDmaRvalid = 1'b0;
        end else begin
            if (mDma) dmaWaits = 0;
            else if (dReq && dmaWaits < STARVE_MAX) dmaWaits++;
            expCpuRvalid = mCpu && !cWe;
            expDmaRvalid = mDma && !dWe;
            if (mCpu && !cWe) expCpuRdata = refMem[cAddr];
            if (mDma && !dWe) expDmaRdata = refMem[dAddr];
            if (mCpu && cWe) refMem[cAddr] = cData;
            if (mDma && dWe) refMem[dAddr] = dData;
        end
        checkOutput("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(expCpuRvalid));
        checkOutput("dma_rvalid", 32'(bus.dma_rvalid), 32'(expDmaRvalid));
        checkOutput("cpu_rdata",  bus.cpu_rdata,       expCpuRdata);
        checkOutput("dma_rdata",  bus.dma_rdata,       expDmaRdata);
    endtask

    task automatic idleCycle(input logic rstN);
        applyStimulus(rstN, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    logic [14:0] dmaPattern;
    logic        cReq, cWe, dReq, dWe, rstRand;
    logic [4:0]  cAddr, dAddr;
    logic [31:0] cData, dData;

    initial begin
        checkCount   = 0;
        passCount    = 0;
        dmaWaits     = 0;
        expCpuRdata  = 32'd0;
        expDmaRdata  = 32'd0;
        expCpuRvalid = 1'b0;
        expDmaRvalid = 1'b0;
        lastCpuGnt   = 1'b0;
        lastDmaGnt   = 1'b0;
        clearMem     = 1'b1;
        for (int i = 0; i < 32; i++) refMem[i] = 32'd0;

        // Reset with a CPU write pending: nothing reaches memory, CPU stalls
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd3, 32'h1111_1111, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        clearMem = 1'b0;
        checkOutput("t1_cpuRdata", bus.cpu_rdata, 32'd0);
        idleCycle(1'b1);

        // CPU write then read of address 3
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t2_cpuRdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        checkOutput("t2_cpuRvalid", 32'(bus.cpu_rvalid), 32'd1);
        idleCycle(1'b1);
        checkOutput("t2_rvalidPulse", 32'(bus.cpu_rvalid), 32'd0);

        // Both requesting continuously: 4 CPU grants then one forced DMA grant
        idleCycle(1'b0);
        dmaPattern = '0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0, 1'b0);
            dmaPattern[i] = bus.dma_rvalid;
        end
        checkOutput("t3_pattern", 32'(dmaPattern), 32'h0000_4210);

        // DMA writes 7 alone, CPU reads it back
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("t4_cpuRdata", bus.cpu_rdata, 32'h1234_5678);

        // Forced DMA read interrupted by reset before its edge
        idleCycle(1'b0);
        for (int i = 0; i < STARVE_MAX; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd7, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd7, 32'd0, 1'b1);
        checkOutput("t5_dmaRvalid", 32'(bus.dma_rvalid), 32'd0);
        checkOutput("t5_dmaRdata", bus.dma_rdata, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd7, 32'd0, 1'b0);
        checkOutput("t5_cpuWinsAfter", 32'(lastCpuGnt), 32'd1);

        // Top address: CPU writes 31, DMA reads it
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd31, 32'd0, 1'b0);
        checkOutput("t6_dmaRdata", bus.dma_rdata, 32'hA5A5_A5A5);

        // Random traffic; a refused request is held unchanged until granted
        cReq = 1'b0; cWe = 1'b0; cAddr = '0; cData = '0;
        dReq = 1'b0; dWe = 1'b0; dAddr = '0; dData = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cReq || lastCpuGnt) begin
                cReq  = ($urandom_range(0, 3) != 0);
                cWe   = 1'($urandom_range(0, 1));
                cAddr = 5'($urandom_range(0, 31));
                cData = $urandom;
            end
            if (!dReq || lastDmaGnt) begin
                dReq  = 1'($urandom_range(0, 1));
                dWe   = 1'($urandom_range(0, 1));
                dAddr = 5'($urandom_range(0, 31));
                dData = $urandom;
            end
            rstRand = ($urandom_range(0, 49) != 0);
            applyStimulus(rstRand, cReq, cWe, cAddr, cData, dReq, dWe, dAddr, dData, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
